array_divider_pipeline: RTL and testbench

Fully pipelined unsigned restoring array divider, the inverse of the team's pipelined array multiplier. It accepts one dividend/divisor pair per clock and returns quotient and remainder a fixed `width` cycles later. Intended for datapaths that must undo or normalise multiplier products at full throughput.

---
 rtl/array_arith_pkg.sv | 22 ++
 rtl/array_divider_pipeline_if.sv | 31 +++
 rtl/array_divider_stage.sv | 63 ++++++
 rtl/array_divider_pipeline.sv | 74 +++++++
 tb/tb_array_divider_pipeline.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/array_arith_pkg.sv
// Shared types and constants for the pipelined array divider.
// Stage bundles are sized for the widest legal operand; narrower builds leave the upper bits at zero.
package array_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 32;

    typedef logic [MAX_WIDTH-1:0] word_t;
    typedef logic [MAX_WIDTH:0]   rem_t;

    localparam word_t DIV0_Q_ONES = '1;
    localparam word_t DIV0_Q_ZERO = '0;

    typedef struct packed {
        logic  valid;
        word_t divisor;
        word_t dividend;
        rem_t  part_rem;
        word_t quot;
    } stage_t;

endpackage

// File: rtl/array_divider_pipeline_if.sv
// Operand/result bus of the pipelined array divider.
// ARRAY_DIVIDER_DIV0_FLAG_EN adds the div0 result flag.
interface array_divider_pipeline_if #(parameter int width = array_arith_pkg::DEFAULT_WIDTH);

    logic             in_valid;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic             out_valid;
    logic [width-1:0] q;
    logic [width-1:0] r;
`ifdef ARRAY_DIVIDER_DIV0_FLAG_EN
    logic             div0;
`endif

    modport master (
        output in_valid, a, b,
        input  out_valid, q, r
`ifdef ARRAY_DIVIDER_DIV0_FLAG_EN
        , input div0
`endif
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, q, r
`ifdef ARRAY_DIVIDER_DIV0_FLAG_EN
        , output div0
`endif
    );

endinterface

// File: rtl/array_divider_stage.sv
// One restoring-division step: resolves quotient bit width-1-index and registers the bundle.
module array_divider_stage
    import array_arith_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int index = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  stage_t stage_in,
    output stage_t stage_out
);

    localparam int BIT = width - 1 - index;

    logic [width:0] trial;
    logic [width:0] dvsr;
    logic           take;
    rem_t           rem_next;
    word_t          quot_next;
    logic           unused_rem;

    logic           valid_q;
    word_t          divisor_q;
    word_t          dividend_q;
    rem_t           rem_q;
    word_t          quot_q;

    always_comb begin
        trial     = {stage_in.part_rem[width-1:0], stage_in.dividend[BIT]};
        dvsr      = {1'b0, stage_in.divisor[width-1:0]};
        take      = (trial >= dvsr);
        rem_next  = '0;
        rem_next[width:0] = take ? (trial - dvsr) : trial;
        quot_next = stage_in.quot;
        quot_next[BIT] = take;
    end

    // The partial remainder never exceeds width bits after a step, so its upper bits are dead.
    assign unused_rem = ^stage_in.part_rem[MAX_WIDTH:width];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= stage_in.valid;
        end
    end

    always_ff @(posedge clk) begin
        divisor_q  <= stage_in.divisor;
        dividend_q <= stage_in.dividend;
        rem_q      <= rem_next;
        quot_q     <= quot_next;
    end

    assign stage_out = '{valid:    valid_q,
                         divisor:  divisor_q,
                         dividend: dividend_q,
                         part_rem: rem_q,
                         quot:     quot_q};

endmodule

// File: rtl/array_divider_pipeline.sv
// Fully pipelined unsigned restoring array divider: one a/b per clock, q and r width cycles later.
// ARRAY_DIVIDER_DIV0_FLAG_EN adds a div0 flag and reports q=0 for zero divisors.
module array_divider_pipeline
    import array_arith_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    array_divider_pipeline_if.slave bus
);

    stage_t pipe [0:width];
    stage_t last;
    logic   unused_last;

    assign pipe[0] = '{valid:    bus.in_valid,
                       divisor:  word_t'(bus.b),
                       dividend: word_t'(bus.a),
                       part_rem: '0,
                       quot:     '0};

    for (genvar k = 0; k < width; k++) begin : g_stage
        array_divider_stage #(
            .width (width),
            .index (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .stage_in  (pipe[k]),
            .stage_out (pipe[k+1])
        );
    end

    assign last        = pipe[width];
    assign unused_last = ^last;

`ifdef ARRAY_DIVIDER_DIV0_FLAG_EN
    logic zero_div;
    assign zero_div = (last.divisor[width-1:0] == '0);

    // A zero divisor reports q=0, r=a and raises div0 instead of the natural all-ones quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.q         <= '0;
            bus.r         <= '0;
            bus.div0      <= 1'b0;
        end else begin
            bus.out_valid <= last.valid;
            if (last.valid) begin
                bus.q    <= zero_div ? DIV0_Q_ZERO[width-1:0] : last.quot[width-1:0];
                bus.r    <= zero_div ? last.dividend[width-1:0] : last.part_rem[width-1:0];
                bus.div0 <= zero_div;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.q         <= '0;
            bus.r         <= '0;
        end else begin
            bus.out_valid <= last.valid;
            if (last.valid) begin
                bus.q <= last.quot[width-1:0];
                bus.r <= last.part_rem[width-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_array_divider_pipeline.sv
// Bench for array_divider_pipeline: 8- and 16-bit instances checked every cycle against a queue model.
// Honours ARRAY_DIVIDER_DIV0_FLAG_EN for the zero-divisor result rules.
module tb_array_divider_pipeline;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    array_divider_pipeline_if #(.width(8))  bus8 ();
    array_divider_pipeline_if #(.width(16)) bus16 ();

    array_divider_pipeline #(.width(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    array_divider_pipeline #(.width(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    typedef struct {
        longint      due;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t        exp_q [2][$];
    int          wd [2] = '{8, 16};
    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_in  [2] = '{0, 0};
    int          n_out [2] = '{0, 0};
    longint      cyc = 0;
    logic [31:0] held_q [2] = '{32'd0, 32'd0};
    logic [31:0] held_r [2] = '{32'd0, 32'd0};
    logic        held_z [2] = '{1'b0, 1'b0};

    logic        ov  [2];
    logic [31:0] oq  [2];
    logic [31:0] orr [2];
    logic        oz  [2];

    assign ov[0]  = bus8.out_valid;
    assign oq[0]  = 32'(bus8.q);
    assign orr[0] = 32'(bus8.r);
    assign ov[1]  = bus16.out_valid;
    assign oq[1]  = 32'(bus16.q);
    assign orr[1] = 32'(bus16.r);
`ifdef ARRAY_DIVIDER_DIV0_FLAG_EN
    assign oz[0]  = bus8.div0;
    assign oz[1]  = bus16.div0;
`else
    assign oz[0]  = 1'b0;
    assign oz[1]  = 1'b0;
`endif

    // Reference arithmetic straight from the quotient/remainder definition.
    function automatic void modelDiv(input int w, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r, output logic dz);
        logic [31:0] ones;
        ones = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        if (b == 32'd0) begin
            dz = 1'b1;
            r  = a;
`ifdef ARRAY_DIVIDER_DIV0_FLAG_EN
            q  = 32'd0;
`else
            q  = ones;
`endif
        end else begin
            dz = 1'b0;
            q  = a / b;
            r  = a % b;
        end
    endfunction

    function automatic void checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Record each accepted operation with the cycle its result is due.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (bus8.in_valid) begin
                modelDiv(8, 32'(bus8.a), 32'(bus8.b), e.q, e.r, e.dz);
                e.due = cyc + 8;
                exp_q[0].push_back(e);
                n_in[0]++;
            end
            if (bus16.in_valid) begin
                modelDiv(16, 32'(bus16.a), 32'(bus16.b), e.q, e.r, e.dz);
                e.due = cyc + 16;
                exp_q[1].push_back(e);
                n_in[1]++;
            end
        end
    end

    // Reset discards everything in flight and clears the held outputs.
    always @(negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            n_in[i]  -= exp_q[i].size();
            exp_q[i].delete();
            held_q[i] = 32'd0;
            held_r[i] = 32'd0;
            held_z[i] = 1'b0;
        end
    end

    task automatic checkOutput(input int i);
        exp_t        e;
        logic        ev;
        ev = 1'b0;
        if (exp_q[i].size() > 0 && exp_q[i][0].due == cyc) begin
            e         = exp_q[i].pop_front();
            ev        = 1'b1;
            held_q[i] = e.q;
            held_r[i] = e.r;
            held_z[i] = e.dz;
        end
        if (ov[i]) n_out[i]++;
        checkValue($sformatf("w%0d_out_valid", wd[i]), 32'(ov[i]), 32'(ev));
        checkValue($sformatf("w%0d_q", wd[i]), oq[i], held_q[i]);
        checkValue($sformatf("w%0d_r", wd[i]), orr[i], held_r[i]);
`ifdef ARRAY_DIVIDER_DIV0_FLAG_EN
        checkValue($sformatf("w%0d_div0", wd[i]), 32'(oz[i]), 32'(held_z[i]));
`endif
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) checkOutput(i);
    end

    task automatic applyStimulus(input logic v8, input logic [7:0] a8, input logic [7:0] b8,
                                 input logic v16, input logic [15:0] a16, input logic [15:0] b16);
        bus8.in_valid  = v8;
        bus8.a         = a8;
        bus8.b         = b8;
        bus16.in_valid = v16;
        bus16.a        = a16;
        bus16.b        = b16;
        @(posedge clk);
        #1;
    endtask

    task automatic applyBoth(input logic v, input logic [15:0] a, input logic [15:0] b);
        applyStimulus(v, a[7:0], b[7:0], v, a, b);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyBoth(1'b0, 16'd0, 16'd0);
    endtask

    task automatic pinModel(input int w, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        modelDiv(w, a, b, q, r, dz);
        checkValue($sformatf("model_q_%0d_%0d", a, b), q, eq);
        checkValue($sformatf("model_r_%0d_%0d", a, b), r, er);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] sa;
        logic [15:0] sb;

        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;

        pinModel(8, 32'd200, 32'd7,   32'd28, 32'd4);
        pinModel(8, 32'd255, 32'd255, 32'd1,  32'd0);
        pinModel(8, 32'd5,   32'd9,   32'd0,  32'd5);
        pinModel(8, 32'd128, 32'd2,   32'd64, 32'd0);
`ifdef ARRAY_DIVIDER_DIV0_FLAG_EN
        pinModel(8, 32'd77,  32'd0,   32'd0,   32'd77);
`else
        pinModel(8, 32'd77,  32'd0,   32'd255, 32'd77);
        pinModel(16, 32'd77, 32'd0,   32'd65535, 32'd77);
`endif

        idle(20);

        applyBoth(1'b1, 16'd200, 16'd7);
        idle(12);

        applyBoth(1'b1, 16'd255, 16'd1);
        applyBoth(1'b1, 16'd255, 16'd255);
        applyBoth(1'b1, 16'd5,   16'd9);
        applyBoth(1'b1, 16'd0,   16'd3);
        applyBoth(1'b1, 16'd128, 16'd2);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd65535, 16'd1);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd65535, 16'd65535);
        idle(20);

        applyBoth(1'b1, 16'd77, 16'd0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd40000, 16'd0);
        idle(20);

        applyBoth(1'b1, 16'd10, 16'd3);
        applyBoth(1'b1, 16'd20, 16'd4);
        applyBoth(1'b1, 16'd30, 16'd5);
        rst_n = 1'b0;
        applyBoth(1'b1, 16'd40, 16'd6);
        rst_n = 1'b1;
        idle(2);
        applyBoth(1'b1, 16'd100, 16'd10);
        idle(20);

        for (int n = 0; n < 10000; n++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            sa = 16'($urandom);
            sb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, ra[7:0], rb[7:0],
                          $urandom_range(0, 3) != 0, sa, sb);
        end
        idle(24);

        for (int i = 0; i < 2; i++) begin
            checkValue($sformatf("w%0d_pending", wd[i]), 32'(exp_q[i].size()), 32'd0);
            checkValue($sformatf("w%0d_result_count", wd[i]), 32'(n_out[i]), 32'(n_in[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
